// File: rtl/pipe_ctrl_if.sv
// Pipeline control bus between the core datapath and pipe_ctrl.
//   master: the datapath side. It drives the stall/flush requests and the multi-cycle op
//           start/len/cancel signals, and it receives the stall vector and status.
//   slave : the controller (pipe_ctrl).
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned STAT_W = 32
);
    logic              stallreq_id;
    logic              stallreq_ex;
    logic              ex_mcyc_start;
    logic [CNT_W-1:0]  ex_mcyc_len;
    logic              ex_mcyc_cancel;
    logic              flush_req;
    logic [5:0]        stall;
    logic              flush;
    logic              mcyc_busy;
    logic [CNT_W-1:0]  mcyc_cnt;
    logic              mcyc_done;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output stallreq_id, stallreq_ex, ex_mcyc_start, ex_mcyc_len, ex_mcyc_cancel, flush_req,
        input  stall, flush, mcyc_busy, mcyc_cnt, mcyc_done, stall_cycles
    );

    modport slave (
        input  stallreq_id, stallreq_ex, ex_mcyc_start, ex_mcyc_len, ex_mcyc_cancel, flush_req,
        output stall, flush, mcyc_busy, mcyc_cnt, mcyc_done, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush controller for the 5-stage core.
//   It merges the ID and EX stall requests and sequences multi-cycle EX ops (div, madd/msub)
//   with a down-counter FSM. While an op runs, PC..EX are frozen and MEM/WB keep draining.
//   flush_req clears every pipeline register and aborts any op that is in flight.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous reset, active low
//   bus  - pipe_ctrl_if.slave. Requests come in from the datapath; the controller drives
//          stall[5:0] (PC,IF,ID,EX,MEM,WB), flush, mcyc_busy, mcyc_cnt, mcyc_done and
//          stall_cycles.
// Build option: define PIPE_STALL_STAT_EN to enable the saturating stall-cycle counter.
//   When the macro is not defined, stall_cycles is tied to zero.
module pipe_ctrl #(
    parameter int unsigned MCYC_MAX = 34,
    parameter int unsigned CNT_W    = 6,
    parameter int unsigned STAT_W   = 32
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;

    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(MCYC_MAX);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, done_q;
    logic             start_ok_c;
    logic [CNT_W-1:0] len_eff_c;
    logic [5:0]       stall_c;
    logic             flush_c;

    // Accept only lengths of 2 or more. Longer requests are clamped to MCYC_MAX.
    always_comb begin
        start_ok_c = bus.ex_mcyc_start && (bus.ex_mcyc_len >= CNT_W'(2));
        len_eff_c  = (bus.ex_mcyc_len > MAX_LEN) ? MAX_LEN : bus.ex_mcyc_len;
    end

    // Next-state logic. mcyc_cnt holds the cycles remaining and reads 1 in the DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush_req) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok_c) begin
                        cnt_d   = len_eff_c - CNT_W'(1);
                        // A 2-cycle op has no BUSY cycle; its result is valid in the next cycle.
                        state_d = (len_eff_c == CNT_W'(2)) ? ST_DONE : ST_BUSY;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_BUSY: begin
                    if (bus.ex_mcyc_cancel) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(2)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == ST_BUSY);
            done_q  <= (state_d == ST_DONE);
        end
    end

    // Stall vector and flush, in priority order. Both are forced low while reset is asserted.
    always_comb begin
        stall_c = STALL_NONE;
        flush_c = 1'b0;
        if (rst) begin
            if (bus.flush_req) begin
                flush_c = 1'b1;
            end else if (start_ok_c || (state_q == ST_BUSY) || bus.stallreq_ex) begin
                stall_c = STALL_EX;
            end else if (bus.stallreq_id) begin
                stall_c = STALL_ID;
            end
        end
    end

    assign bus.stall     = stall_c;
    assign bus.flush     = flush_c;
    assign bus.mcyc_busy = busy_q;
    assign bus.mcyc_cnt  = cnt_q;
    assign bus.mcyc_done = done_q;

`ifdef PIPE_STALL_STAT_EN
    logic [STAT_W-1:0] stat_q;

    // Saturating count of cycles in which any stage is held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_q <= '0;
        end else if ((stall_c != STALL_NONE) && (stat_q != {STAT_W{1'b1}})) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign bus.stall_cycles = stat_q;
`else
    assign bus.stall_cycles = STAT_W'(0);
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. It runs directed scenarios followed by random
// stimulus, and checks every cycle against a reference model. The model tracks an op by
// the absolute cycle in which it completes, instead of keeping a counter FSM.
module tb_pipe_ctrl;
    localparam int unsigned MCYC_MAX = 34;
    localparam int unsigned CNT_W    = 6;
`ifdef PIPE_STALL_STAT_EN
    localparam int unsigned STAT_W   = 4;
`else
    localparam int unsigned STAT_W   = 32;
`endif

    logic clk;
    logic rst;

    pipe_ctrl_if #(.CNT_W(CNT_W), .STAT_W(STAT_W)) bus ();

    pipe_ctrl #(.MCYC_MAX(MCYC_MAX), .CNT_W(CNT_W), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int     cyc       = 0;
    bit     op_active = 1'b0;
    int     end_cyc   = 0;
    longint exp_stat  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_inputs(input logic id, input logic ex, input logic st,
                              input logic [CNT_W-1:0] len, input logic cn, input logic fl);
        bus.stallreq_id    = id;
        bus.stallreq_ex    = ex;
        bus.ex_mcyc_start  = st;
        bus.ex_mcyc_len    = len;
        bus.ex_mcyc_cancel = cn;
        bus.flush_req      = fl;
    endtask

    // Drive one cycle, check every output against the model, then advance the model.
    task automatic step(input logic id, input logic ex, input logic st,
                        input logic [CNT_W-1:0] len, input logic cn, input logic fl);
        bit         exp_busy, exp_done, start_ok, can_start;
        int         exp_cnt, eff_len;
        logic [5:0] exp_stall;
        logic       exp_flush;
        longint     stat_max;
        @(negedge clk);
        set_inputs(id, ex, st, len, cn, fl);
        #1;
        exp_busy  = op_active && (cyc < end_cyc);
        exp_done  = op_active && (cyc == end_cyc);
        exp_cnt   = op_active ? (end_cyc - cyc + 1) : 0;
        start_ok  = st && (int'(len) >= 2);
        exp_flush = fl;
        if (fl)                               exp_stall = 6'b000000;
        else if (start_ok || exp_busy || ex)  exp_stall = 6'b001111;
        else if (id)                          exp_stall = 6'b000111;
        else                                  exp_stall = 6'b000000;

        check("stall", 64'(bus.stall), 64'(exp_stall));
        check("flush", 64'(bus.flush), 64'(exp_flush));
        check("busy",  64'(bus.mcyc_busy), 64'(exp_busy));
        check("cnt",   64'(bus.mcyc_cnt), 64'(exp_cnt));
        check("done",  64'(bus.mcyc_done), 64'(exp_done));
        check("stat",  64'(bus.stall_cycles), 64'(exp_stat));

        // Advance the model to what the next edge should produce.
        can_start = !op_active || exp_done;
        eff_len   = (int'(len) > int'(MCYC_MAX)) ? int'(MCYC_MAX) : int'(len);
        if (fl) begin
            op_active = 1'b0;
        end else if (exp_busy && cn) begin
            op_active = 1'b0;
        end else if (can_start && start_ok) begin
            op_active = 1'b1;
            end_cyc   = cyc + eff_len - 1;
        end else if (exp_done) begin
            op_active = 1'b0;
        end
`ifdef PIPE_STALL_STAT_EN
        stat_max = (longint'(1) << STAT_W) - 1;
        if (exp_stall != 6'b0 && exp_stat < stat_max) exp_stat++;
`else
        stat_max = 0;
`endif
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0);
    endtask

    // Hold reset with every request high; outputs must stay quiet.
    task automatic reset_check(input string tag);
        check({tag, "_stall"}, 64'(bus.stall), 64'd0);
        check({tag, "_flush"}, 64'(bus.flush), 64'd0);
        check({tag, "_busy"},  64'(bus.mcyc_busy), 64'd0);
        check({tag, "_cnt"},   64'(bus.mcyc_cnt), 64'd0);
        check({tag, "_done"},  64'(bus.mcyc_done), 64'd0);
        check({tag, "_stat"},  64'(bus.stall_cycles), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        set_inputs(1, 1, 1, CNT_W'(4), 1, 1);
        #1;
        reset_check("rst0");
        repeat (3) @(posedge clk);
        #1;
        reset_check("rst1");
        @(negedge clk);
        set_inputs(0, 0, 0, '0, 0, 0);
        rst = 1'b1;

        // Basic len=4 op, then plain idle cycles
        step(0, 0, 1, CNT_W'(4), 0, 0);
        idle(4);
        // Cancel one cycle after the start
        step(0, 0, 1, CNT_W'(4), 0, 0);
        step(0, 0, 0, '0, 1, 0);
        idle(3);
        // Flush during a maximum-length op
        step(0, 0, 1, CNT_W'(34), 0, 0);
        step(0, 0, 0, '0, 0, 1);
        idle(3);
        // Request priorities, and starts too short to do anything
        step(1, 1, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        step(0, 1, 0, '0, 0, 0);
        step(0, 0, 1, CNT_W'(1), 0, 0);
        step(0, 0, 1, CNT_W'(0), 0, 0);
        step(1, 0, 1, CNT_W'(1), 0, 0);
        idle(2);
        // Shortest op, then a start ignored while busy, then a back-to-back start in DONE
        step(0, 0, 1, CNT_W'(2), 0, 0);
        idle(2);
        step(0, 0, 1, CNT_W'(3), 0, 0);
        step(0, 0, 1, CNT_W'(5), 0, 0);
        step(0, 0, 1, CNT_W'(3), 0, 0);
        idle(4);
        // Over-long length clamps to MCYC_MAX
        step(0, 0, 1, CNT_W'(63), 0, 0);
        idle(36);
        // Flush takes priority over a start in the same cycle
        step(0, 0, 1, CNT_W'(6), 0, 1);
        idle(2);

        // Asynchronous reset in the middle of an op
        step(0, 0, 1, CNT_W'(10), 0, 0);
        idle(3);
        @(negedge clk);
        #2;
        rst = 1'b0;
        set_inputs(1, 1, 1, CNT_W'(8), 0, 0);
        #1;
        reset_check("rstmid");
        op_active = 1'b0;
        exp_stat  = 0;
        @(negedge clk);
        set_inputs(0, 0, 0, '0, 0, 0);
        rst = 1'b1;
        cyc++;

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 99) < 15), CNT_W'($urandom_range(0, 63)),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
        end
        idle(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
